ctrl_word_encoder: RTL and testbench

CTRL_WORD_ENCODER -- requirements
Module: ctrl_word_encoder

---
 rtl/ctrl_word_encoder.sv | 155 +++++++++++++++
 tb/tb_ctrl_word_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_word_encoder.sv
// Re-encodes a decoded control word back into its 6-bit instruction opcode through a
// one-deep valid/ready output register. Optional per-class transfer counters: CTRL_ENC_STATS_EN.
module ctrl_word_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RegDst,
    input  logic       Jump,
    input  logic       Branch,
    input  logic       MemRead,
    input  logic       MemToReg,
    input  logic       MemWrite,
    input  logic       ALUSrc,
    input  logic       RegWrite,
    input  logic [2:0] ALUOp,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] opcode,
    output logic       illegal,
    input  logic [3:0] stat_sel,
    input  logic       stat_clr,
    output logic [7:0] stat_count
);

    typedef struct packed {
        logic       illegal;
        logic [5:0] opcode;
        logic [3:0] cls;
    } dec_t;

    localparam logic [5:0] OP_ILLEGAL  = 6'b111111;
    localparam logic [3:0] CLS_ILLEGAL = 4'd9;
    localparam int         NUM_CLS     = 10;

    // Exact-match lookup; any word outside the table maps to the illegal class.
    function automatic dec_t decode_word(input logic [10:0] word);
        dec_t d;
        d.illegal = 1'b0;
        case (word)
            11'b1001_0000_010: begin d.opcode = 6'b000000; d.cls = 4'd0; end
            11'b0101_0000_000: begin d.opcode = 6'b001000; d.cls = 4'd1; end
            11'b0101_0000_011: begin d.opcode = 6'b001101; d.cls = 4'd2; end
            11'b0101_0000_100: begin d.opcode = 6'b001100; d.cls = 4'd3; end
            11'b0101_0000_101: begin d.opcode = 6'b001010; d.cls = 4'd4; end
            11'b0111_1000_000: begin d.opcode = 6'b100011; d.cls = 4'd5; end
            11'b0100_0100_000: begin d.opcode = 6'b101011; d.cls = 4'd6; end
            11'b0000_0010_001: begin d.opcode = 6'b000100; d.cls = 4'd7; end
            11'b0000_0001_000: begin d.opcode = 6'b000010; d.cls = 4'd8; end
            default: begin
                d.opcode  = OP_ILLEGAL;
                d.cls     = CLS_ILLEGAL;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic [10:0] word_s;
    dec_t        dec_s;
    logic        xfer_s;

    logic        out_valid_q, out_valid_d;
    logic [5:0]  opcode_q, opcode_d;
    logic        illegal_q, illegal_d;

    assign word_s   = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
                       Branch, Jump, ALUOp};
    assign dec_s    = decode_word(word_s);
    assign in_ready = !out_valid_q || out_ready;
    assign xfer_s   = in_valid && in_ready;

    // Output register next state: load on transfer, drop valid on a bare accept, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        illegal_d   = illegal_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            opcode_d    = dec_s.opcode;
            illegal_d   = dec_s.illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= 6'b000000;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign illegal   = illegal_q;

`ifdef CTRL_ENC_STATS_EN
    logic [7:0] cnt_q [NUM_CLS];
    logic [7:0] cnt_d [NUM_CLS];

    // Counter next state: clear wins over increment; increments saturate at 255.
    always_comb begin
        for (int i = 0; i < NUM_CLS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clr) begin
                cnt_d[i] = 8'd0;
            end else if (xfer_s && (dec_s.cls == 4'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLS; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CLS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read mux; selectors beyond the last class read as zero.
    always_comb begin
        stat_count = 8'd0;
        for (int i = 0; i < NUM_CLS; i++) begin
            if (stat_sel == 4'(i)) begin
                stat_count = cnt_q[i];
            end else begin
                stat_count = stat_count;
            end
        end
    end
`else
    logic unused_stats_s;

    assign stat_count     = 8'd0;
    assign unused_stats_s = ^{stat_sel, stat_clr, dec_s.cls};
`endif

endmodule

// File: tb/tb_ctrl_word_encoder.sv
// Scoreboard bench for ctrl_word_encoder: directed scenarios plus random traffic,
// checked against a table-lookup reference model and a per-class counter model.
module tb_ctrl_word_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite;
    logic [2:0] ALUOp;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [5:0] opcode;
    logic       illegal;
    logic [3:0] stat_sel;
    logic       stat_clr;
    logic [7:0] stat_count;

`ifdef CTRL_ENC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q [$];
    int         cnt_m [10];

    logic [10:0] tw  [9] = '{11'b10010000010, 11'b01010000000, 11'b01010000011,
                             11'b01010000100, 11'b01010000101, 11'b01111000000,
                             11'b01000100000, 11'b00000010001, 11'b00000001000};
    logic [5:0]  top [9] = '{6'b000000, 6'b001000, 6'b001101, 6'b001100, 6'b001010,
                             6'b100011, 6'b101011, 6'b000100, 6'b000010};
    localparam logic [10:0] W_BAD = 11'b10010100010;

    ctrl_word_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
        .MemToReg(MemToReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .illegal(illegal),
        .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_count(stat_count)
    );

    always #5 clk = ~clk;

    // Reference: index of the matching table row, or 9 for no match.
    function automatic int ref_class(input logic [10:0] w);
        for (int i = 0; i < 9; i++) if (tw[i] == w) return i;
        return 9;
    endfunction

    function automatic logic [6:0] ref_out(input logic [10:0] w);
        int c;
        c = ref_class(w);
        return (c == 9) ? {1'b1, 6'b111111} : {1'b0, top[c]};
    endfunction

    function automatic int ref_stat(input logic [3:0] sel);
        if (!STATS || sel > 4'd9) return 0;
        return cnt_m[sel];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input logic [10:0] w);
        {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = w;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 10; i++) cnt_m[i] = 0;
    endtask

    // One cycle: drive after the edge, observe at the falling edge, update the model.
    task automatic step(input logic v, input logic [10:0] w, input logic ordy,
                        input logic [3:0] sel, input logic clr);
        int c;
        @(posedge clk);
        #1;
        in_valid  = v;
        set_word(w);
        out_ready = ordy;
        stat_sel  = sel;
        stat_clr  = clr;
        @(negedge clk);
        check("stat_count", int'(stat_count), ref_stat(sel));
        if (clr) begin
            for (int i = 0; i < 10; i++) cnt_m[i] = 0;
        end else if (v && in_ready) begin
            c = ref_class(w);
            if (cnt_m[c] < 255) cnt_m[c]++;
        end
        if (v && in_ready) exp_q.push_back(ref_out(w));
    endtask

    // Monitor: every output accept pops the oldest expected response.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'({illegal, opcode}), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", int'({illegal, opcode}), int'(e));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stat_sel = 4'd0; stat_clr = 1'b0;
        set_word(11'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_opcode", int'(opcode), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_in_ready", int'(in_ready), 1);
        #2 rst_n = 1'b1;

        // Sweep of all table words, back to back, latency one cycle.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tw[i], 1'b1, 4'(i), 1'b0);
            check("sweep_xfer_ready", int'(in_ready), 1);
            if (i > 0) begin
                check("sweep_opcode", int'(opcode), int'(top[i-1]));
                check("sweep_illegal", int'(illegal), 0);
                check("sweep_valid", int'(out_valid), 1);
            end
        end
        step(1'b0, 11'd0, 1'b1, 4'd8, 1'b0);
        check("sweep_opcode_last", int'(opcode), int'(top[8]));

        // Illegal word.
        step(1'b1, W_BAD, 1'b1, 4'd9, 1'b0);
        step(1'b0, 11'd0, 1'b1, 4'd9, 1'b0);
        check("illegal_opcode", int'(opcode), 63);
        check("illegal_flag", int'(illegal), 1);
        check("illegal_stat", int'(stat_count), STATS ? 1 : 0);

        // Backpressure: lw held for three stalled cycles, then sw follows.
        step(1'b1, tw[5], 1'b0, 4'd5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, tw[6], 1'b0, 4'd6, 1'b0);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_opcode_hold", int'(opcode), int'(top[5]));
            check("bp_valid_hold", int'(out_valid), 1);
        end
        step(1'b1, tw[6], 1'b1, 4'd6, 1'b0);
        check("bp_release_ready", int'(in_ready), 1);
        step(1'b0, 11'd0, 1'b1, 4'd6, 1'b0);
        check("bp_sw_opcode", int'(opcode), int'(top[6]));

        // Saturation and clear-over-increment.
        for (int k = 0; k < 300; k++) step(1'b1, tw[7], 1'b1, 4'd7, 1'b0);
        step(1'b0, 11'd0, 1'b1, 4'd7, 1'b0);
        check("sat_255", int'(stat_count), STATS ? 255 : 0);
        step(1'b1, tw[7], 1'b1, 4'd7, 1'b1);
        step(1'b0, 11'd0, 1'b1, 4'd7, 1'b0);
        check("clr_zero", int'(stat_count), 0);

        // Asynchronous reset while addi is held at the output.
        step(1'b1, tw[1], 1'b0, 4'd1, 1'b0);
        step(1'b0, 11'd0, 1'b0, 4'd1, 1'b0);
        check("pre_rst_valid", int'(out_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_opcode", int'(opcode), 0);
        check("arst_in_ready", int'(in_ready), 1);
        model_reset();
        for (int s = 0; s < 16; s++) begin
            stat_sel = 4'(s);
            #1 check("arst_stat", int'(stat_count), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 11'd0, 1'b1, 4'd1, 1'b0);
        check("post_rst_valid", int'(out_valid), 0);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            logic [10:0] w;
            w = ($urandom_range(0, 1) == 0) ? tw[$urandom_range(0, 8)] : 11'($urandom);
            step(1'($urandom_range(0, 1)), w, ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));
        end

        // Drain outstanding responses within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step(1'b0, 11'd0, 1'b1, 4'd0, 1'b0);
        step(1'b0, 11'd0, 1'b1, 4'd0, 1'b0);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
